// File: rtl/accum_pkg.sv
// Shared types and constants for the 16-bit sample accumulator.
package accum_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Complete registered state of the accumulator, updated as one unit
  typedef struct packed {
    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               valid;
    logic               ready;
  } acc_regs_t;

  localparam acc_regs_t REGS_RST = '{
    state: ST_IDLE,
    acc:   '0,
    cnt:   '0,
    ovf:   1'b0,
    valid: 1'b0,
    ready: 1'b1
  };

endpackage

// File: rtl/adder_16bit.sv
// 16-bit unsigned ripple adder with carry in/out.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = 17'({1'b0, a}) + 17'({1'b0, b}) + 17'(cin);

endmodule

// File: rtl/accum_16bit.sv
// Accumulates NUM_SAMPLES unsigned 16-bit samples into one result with
// valid/ready handoff. Optional macro ACCUM_SATURATE_EN clamps on overflow.
module accum_16bit
  import accum_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [DATA_W-1:0] acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow_flag,
  output logic [CNT_W-1:0]  sample_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES);

  acc_regs_t         r, r_n;
  logic [DATA_W-1:0] sum;
  logic              carry;
  logic [DATA_W-1:0] acc_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  adder_16bit u_adder (
    .a    (r.acc),
    .b    (data_in),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Once clamped, every later add either carries or adds zero, so FFFF holds
`ifdef ACCUM_SATURATE_EN
  assign acc_nxt = carry ? {DATA_W{1'b1}} : sum;
`else
  assign acc_nxt = sum;
`endif

  assign cnt_nxt = r.cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r <= REGS_RST;
    else        r <= r_n;
  end

  // Next-state and registered-output logic
  always_comb begin
    r_n = r;
    if (clear) begin
      r_n = REGS_RST;
    end else begin
      unique case (r.state)
        ST_IDLE, ST_ACCUM: begin
          if (data_valid) begin
            r_n.acc   = acc_nxt;
            r_n.cnt   = cnt_nxt;
            r_n.ovf   = r.ovf | carry;
            r_n.state = (cnt_nxt == LAST_CNT) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (acc_ready) r_n = REGS_RST;
        end
        default: r_n = REGS_RST;
      endcase
    end
    r_n.valid = (r_n.state == ST_DONE);
    r_n.ready = (r_n.state != ST_DONE);
  end

  assign data_ready    = r.ready;
  assign acc_out       = r.acc;
  assign acc_valid     = r.valid;
  assign overflow_flag = r.ovf;
  assign sample_count  = r.cnt;

endmodule

// File: tb/tb_accum_16bit.sv
// Self-checking bench for accum_16bit: directed scenarios then random traffic
// against a running-total reference model.
module tb_accum_16bit;

  localparam int unsigned NS = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;
  logic        overflow_flag;
  logic [7:0]  sample_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: exact total of accepted samples, count, result-pending flag
  int m_total;
  int m_count;
  bit m_pending;

  accum_16bit #(.NUM_SAMPLES(NS)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .acc_out       (acc_out),
    .acc_valid     (acc_valid),
    .acc_ready     (acc_ready),
    .overflow_flag (overflow_flag),
    .sample_count  (sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_acc();
    if (m_total <= 65535) return 16'(m_total);
`ifdef ACCUM_SATURATE_EN
    return 16'hFFFF;
`else
    return 16'(m_total % 65536);
`endif
  endfunction

  task automatic model_reset();
    m_total   = 0;
    m_count   = 0;
    m_pending = 0;
  endtask

  task automatic model_edge();
    if (clear) begin
      model_reset();
    end else if (m_pending) begin
      if (acc_ready) model_reset();
    end else if (data_valid) begin
      m_total += int'(data_in);
      m_count++;
      if (m_count == int'(NS)) m_pending = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".acc_out"},  32'(acc_out),       32'(exp_acc()));
    check({tag, ".ovf"},      32'(overflow_flag), 32'(m_total > 65535));
    check({tag, ".count"},    32'(sample_count),  32'(m_count));
    check({tag, ".valid"},    32'(acc_valid),     32'(m_pending));
    check({tag, ".ready"},    32'(data_ready),    32'(!m_pending));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic send(input string tag, input logic [15:0] d);
    data_in    = d;
    data_valid = 1'b1;
    step(tag);
  endtask

  task automatic idle_inputs();
    data_valid = 1'b0;
    data_in    = 16'h0;
    clear      = 1'b0;
    acc_ready  = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    n_rst = 1'b1;
    step("post_reset");

    // Basic sum 1..4, handed off immediately
    send("sum1", 16'd1);
    send("sum2", 16'd2);
    send("sum3", 16'd3);
    send("sum4", 16'd4);
    check("basic.acc_out", 32'(acc_out), 32'h000A);
    data_valid = 1'b0;
    acc_ready  = 1'b1;
    step("basic.handoff");
    acc_ready  = 1'b0;

    // Overflow within one result
    send("ovf1", 16'hFFF0);
    send("ovf2", 16'h0020);
    send("ovf3", 16'h0000);
    send("ovf4", 16'h0000);
`ifdef ACCUM_SATURATE_EN
    check("ovf.acc_out", 32'(acc_out), 32'hFFFF);
`else
    check("ovf.acc_out", 32'(acc_out), 32'h0010);
`endif
    check("ovf.flag", 32'(overflow_flag), 32'd1);

    // Backpressure in DONE with samples offered
    data_in = 16'h1234;
    for (int i = 0; i < 5; i++) step("bp.hold");
    check("bp.count", 32'(sample_count), 32'd4);
    data_valid = 1'b0;
    acc_ready  = 1'b1;
    step("bp.release");
    acc_ready  = 1'b0;

    // Clear after two samples, concurrent sample discarded
    send("clr1", 16'd7);
    send("clr2", 16'd9);
    data_in    = 16'd100;
    clear      = 1'b1;
    step("clr.abort");
    clear      = 1'b0;
    check("clr.count", 32'(sample_count), 32'd0);
    data_valid = 1'b0;
    step("clr.idle");

    // Async reset between clock edges mid-accumulation
    send("ar1", 16'd5);
    send("ar2", 16'd6);
    data_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    compare_all("ar.async");
    n_rst = 1'b1;
    send("ar.n1", 16'd1);
    send("ar.n2", 16'd1);
    send("ar.n3", 16'd1);
    check("ar.novalid", 32'(acc_valid), 32'd0);
    send("ar.n4", 16'd1);
    check("ar.valid", 32'(acc_valid), 32'd1);
    data_valid = 1'b0;
    acc_ready  = 1'b1;
    step("ar.handoff");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      data_valid = ($urandom_range(0, 3) != 0);
      acc_ready  = ($urandom_range(0, 2) == 0);
      clear      = ($urandom_range(0, 60) == 0);
      data_in    = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                               : 16'($urandom);
      step("rand");
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
